// File: rtl/m20k_fifo_controller_pkg.sv
// Shared constants and types for the M20K FIFO controller: memory timing,
// sticky error flags and the read-credit rule.
package m20k_fifo_controller_pkg;

  localparam int M20K_READ_LATENCY = 3;
  localparam int M20K_WRITE_COMMIT = 2;

  typedef struct packed {
    logic overflow;
    logic ecc;
  } sticky_t;

  // A read may be issued only while every word already in flight still has a
  // guaranteed seat in the skid buffer.
  function automatic logic has_credit(input int unsigned inflight,
                                      input int unsigned skid_count,
                                      input int unsigned capacity);
    return (inflight + skid_count) < capacity;
  endfunction

endpackage

// File: rtl/m20k_fifo_controller_skid_buffer.sv
// Small register-based FIFO that absorbs words returning from the memory read
// pipeline; exposes its occupancy so the controller can budget reads.
module fifo_skid_buffer #(
  parameter int WIDTH      = 20,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o
);

  localparam int ENTRIES = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [0:ENTRIES-1];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;

  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign empty_o   = (count_o == '0);
  assign rd_data_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (DEPTH_LOG2+1)'(wr_en_i);
    rd_ptr_d = rd_ptr_q + (DEPTH_LOG2+1)'(rd_en_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/m20k_fifo_controller.sv
// Drives one external M20K block as a single-clock FIFO: push port in, valid/ready
// pop port out, hiding the write-commit delay and the read latency.
module m20k_fifo_controller
  import m20k_fifo_controller_pkg::*;
#(
  parameter int WIDTH              = 20,
  parameter int DEPTH_LOG2         = 9,
  parameter int READ_LATENCY       = M20K_READ_LATENCY,
  parameter int SKID_DEPTH_LOG2    = 3,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      pushData,
  output logic                  full,
  output logic                  almostFull,
  output logic                  outValid,
  output logic [WIDTH-1:0]      outData,
  input  logic                  outReady,
  output logic                  memWriteEnable,
  output logic [DEPTH_LOG2-1:0] memWriteAddr,
  output logic [WIDTH-1:0]      memDataIn,
  output logic                  memReadAddressStall,
  output logic [DEPTH_LOG2-1:0] memReadAddr,
  input  logic [WIDTH-1:0]      memDataOut,
  input  logic                  memEccStatus,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic                  overflowError,
  output logic                  eccError
);

  localparam int PW       = DEPTH_LOG2 + 1;
  localparam int SCW      = SKID_DEPTH_LOG2 + 1;
  localparam int SKID_CAP = 1 << SKID_DEPTH_LOG2;
  localparam logic [PW-1:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PW-1:0] AF_LEVEL = CAPACITY - PW'(ALMOST_FULL_MARGIN);

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           commit_ptr_q, commit_ptr_d;
  logic                    commit_pend_q, commit_pend_d;
  logic [READ_LATENCY-1:0] ret_pipe_q, ret_pipe_d;
  logic [SCW-1:0]          inflight_q, inflight_d;
  logic [DEPTH_LOG2-1:0]   rd_addr_q, rd_addr_d;
  sticky_t                 sticky_q, sticky_d;

  logic           wr_en;
  logic           issue;
  logic           ret_valid;
  logic           pop;
  logic [SCW-1:0] skid_count;
  logic           skid_empty;

  assign usedw      = wr_ptr_q - rd_ptr_q;
  assign full       = (usedw == CAPACITY);
  assign almostFull = (usedw >= AF_LEVEL);

  assign wr_en          = push & ~full & ~rst;
  assign memWriteEnable = wr_en;
  assign memWriteAddr   = wr_ptr_q[DEPTH_LOG2-1:0];
  assign memDataIn      = pushData;

  // Credit uses registered counts only, so outReady never reaches the read port.
  assign issue = (rd_ptr_q != commit_ptr_q) &&
                 has_credit(32'(inflight_q), 32'(skid_count), 32'(SKID_CAP));
  assign memReadAddressStall = ~issue;
  assign memReadAddr         = rd_addr_d;

  assign ret_valid     = ret_pipe_q[READ_LATENCY-1];
  assign outValid      = ~skid_empty;
  assign pop           = outValid & outReady;
  assign overflowError = sticky_q.overflow;
  assign eccError      = sticky_q.ecc;

  // The write-commit delay is the commit_pend stage plus commit_ptr itself:
  // a write accepted in cycle t is visible to the issue test from t+2.
  always_comb begin
    wr_ptr_d         = wr_ptr_q + PW'(wr_en);
    rd_ptr_d         = rd_ptr_q + PW'(issue);
    commit_pend_d    = wr_en;
    commit_ptr_d     = commit_ptr_q + PW'(commit_pend_q);
    ret_pipe_d       = {ret_pipe_q[READ_LATENCY-2:0], issue};
    inflight_d       = inflight_q + SCW'(issue) - SCW'(ret_valid);
    rd_addr_d        = issue ? rd_ptr_q[DEPTH_LOG2-1:0] : rd_addr_q;
    sticky_d.overflow = sticky_q.overflow | (push & full);
    sticky_d.ecc      = sticky_q.ecc | (ret_valid & memEccStatus);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      commit_pend_q <= 1'b0;
      ret_pipe_q    <= '0;
      inflight_q    <= '0;
      rd_addr_q     <= '0;
      sticky_q      <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      commit_pend_q <= commit_pend_d;
      ret_pipe_q    <= ret_pipe_d;
      inflight_q    <= inflight_d;
      rd_addr_q     <= rd_addr_d;
      sticky_q      <= sticky_d;
    end
  end

  fifo_skid_buffer #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (SKID_DEPTH_LOG2)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (ret_valid),
    .wr_data_i (memDataOut),
    .rd_en_i   (pop),
    .rd_data_o (outData),
    .count_o   (skid_count),
    .empty_o   (skid_empty)
  );

endmodule
